// File: rtl/prog_loader_pkg.sv
// Shared types for the boot-time program loader.
// Frame parser states and default framing byte.
package prog_loader_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in from UART RX and word write port out to imem.
// master = loader side, slave = environment side.
interface prog_loader_if #(
  parameter int ADDR_WIDTH = 12
) ();

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/prog_loader_byte_packer.sv
// Packs little-endian bytes into 32-bit words.
// word/word_valid present the completed word in the cycle of its 4th byte.
module prog_loader_byte_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        push,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  idx;
  logic [31:0] sr;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      idx <= '0;
      sr  <= '0;
    end else if (push) begin
      idx <= idx + 2'd1;
      sr  <= {data, sr[31:8]};
    end
  end

  // newest byte lands in the top lane, so byte 0 ends up at [7:0]
  assign word       = {data, sr[31:8]};
  assign word_valid = push && (idx == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses framed UART bytes, writes imem from word 0,
// and releases the core reset only after a good checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_WIDTH = 12,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  prog_loader_if.master       bus,
  output logic                cpu_rst_n,
  output logic                load_done,
  output logic                load_err,
  output logic [ADDR_WIDTH:0] word_count
);

  localparam logic [ADDR_WIDTH:0] MAX_WORDS =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t state;
  state_t state_nxt;

  logic                  ready_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [ADDR_WIDTH:0]   wc_q;
  logic [ADDR_WIDTH:0]   len_q;
  logic [7:0]            csum_q;

  logic        accept;
  logic        is_sync;
  logic        restart;
  logic        push;
  logic        len_big;
  logic        last_word;
  logic [31:0] word;
  logic        word_valid;

  assign accept    = bus.rx_valid && ready_q;
  assign is_sync   = (bus.rx_data == SYNC_BYTE);
  assign len_big   = (word > 32'(MAX_WORDS));
  assign last_word = ((wc_q + 1'b1) == len_q);

  prog_loader_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .push       (push),
    .data       (bus.rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    push      = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (accept && is_sync) begin
          restart   = 1'b1;
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        push = accept;
        if (word_valid) begin
          if (len_big) begin
            state_nxt = S_ERR;
          end else if (word == '0) begin
            state_nxt = S_CSUM;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        push = accept;
        if (word_valid && last_word) begin
          state_nxt = S_CSUM;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (bus.rx_data == csum_q) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ERR;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wc_q    <= '0;
      len_q   <= '0;
      csum_q  <= '0;
    end else begin
      ready_q <= 1'b1;
      we_q    <= 1'b0;
      if (restart) begin
        wc_q   <= '0;
        csum_q <= '0;
      end else if (push) begin
        csum_q <= csum_q ^ bus.rx_data;
      end
      if (state == S_LEN && word_valid) begin
        len_q <= word[ADDR_WIDTH:0];
      end
      if (state == S_DATA && word_valid) begin
        we_q    <= 1'b1;
        addr_q  <= wc_q[ADDR_WIDTH-1:0];
        wdata_q <= word;
        wc_q    <= wc_q + 1'b1;
      end
    end
  end

  assign bus.rx_ready   = ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;

  assign cpu_rst_n  = (state == S_DONE);
  assign load_done  = (state == S_DONE);
  assign load_err   = (state == S_ERR);
  assign word_count = wc_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader with a frame-position
// reference model checked every cycle.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int AW   = 12;
  localparam int MAXW = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_WIDTH(AW)) bus ();

  logic          cpu_rst_n;
  logic          load_done;
  logic          load_err;
  logic [AW:0]   word_count;

  prog_loader #(
    .ADDR_WIDTH (AW),
    .SYNC_BYTE  (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cpu_rst_n  (cpu_rst_n),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t",
                 nm, act, exp, $time);
    end
  endtask

  // model: outputs derived from position of each byte in the frame
  bit          m_ready;
  bit          m_we;
  int          m_addr;
  logic [31:0] m_wdata;
  bit          m_done;
  bit          m_err;
  bit          m_in;
  int          m_pos;
  longint      m_n;
  logic [7:0]  m_csum;
  int          m_wc;
  logic [31:0] m_buf;

  task automatic model_byte(input logic [7:0] b);
    if (!m_in) begin
      if (b == 8'hA5) begin
        m_in = 1; m_pos = 0; m_n = 0; m_csum = 0;
        m_wc = 0; m_buf = 0; m_done = 0; m_err = 0;
      end
      return;
    end
    m_pos++;
    if (m_pos <= 4) begin
      m_n = m_n | (longint'(b) << (8 * (m_pos - 1)));
      m_csum = m_csum ^ b;
      if (m_pos == 4 && m_n > MAXW) begin
        m_err = 1; m_in = 0;
      end
    end else if (m_pos <= 4 + 4 * m_n) begin
      m_buf = m_buf | (32'(b) << (8 * ((m_pos - 5) % 4)));
      m_csum = m_csum ^ b;
      if ((m_pos - 4) % 4 == 0) begin
        m_we = 1; m_addr = m_wc; m_wdata = m_buf;
        m_wc++; m_buf = 0;
      end
    end else begin
      if (b == m_csum) m_done = 1;
      else m_err = 1;
      m_in = 0;
    end
  endtask

  always @(posedge clk) begin : model
    bit acc;
    acc = bus.rx_valid && m_ready;
    if (rst) begin
      m_ready = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_done = 0; m_err = 0; m_in = 0; m_pos = 0;
      m_n = 0; m_csum = 0; m_wc = 0; m_buf = 0;
    end else begin
      m_ready = 1;
      m_we = 0;
      if (acc) model_byte(bus.rx_data);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rx_ready", bus.rx_ready, m_ready);
      check("imem_we", bus.imem_we, m_we);
      check("imem_addr", bus.imem_addr, m_addr[AW-1:0]);
      check("imem_wdata", bus.imem_wdata, m_wdata);
      check("cpu_rst_n", cpu_rst_n, m_done);
      check("load_done", load_done, m_done);
      check("load_err", load_err, m_err);
      check("word_count", word_count, m_wc[AW:0]);
    end
  end

  logic [31:0] cap_mem [MAXW];
  int          wr_count = 0;

  always @(posedge clk) begin
    if (bus.imem_we) begin
      cap_mem[bus.imem_addr] <= bus.imem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  logic [31:0] wq [$];
  logic [7:0]  last_csum;
  logic [31:0] last_word;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    idle($urandom_range(gap, 0));
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
  endtask

  task automatic send_frame(input logic [31:0] n,
                            input bit stop_len,
                            input bit use_calc,
                            input logic [7:0] alt,
                            input int gap);
    logic [7:0]  cs;
    logic [7:0]  b;
    logic [31:0] w;
    cs = 8'h00;
    send(8'hA5, gap);
    for (int i = 0; i < 4; i++) begin
      b = n[8*i +: 8];
      cs = cs ^ b;
      send(b, gap);
    end
    if (stop_len) begin
      idle(2);
      return;
    end
    for (int wi = 0; wi < int'(n); wi++) begin
      w = (wi < wq.size()) ? wq[wi] : $urandom;
      last_word = w;
      for (int k = 0; k < 4; k++) begin
        b = w[8*k +: 8];
        cs = cs ^ b;
        send(b, gap);
      end
    end
    last_csum = cs;
    send(use_calc ? cs : alt, gap);
    idle(2);
  endtask

  int base;

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst = 1'b1;
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.rx_ready, 0);
    check("rst_cpu", cpu_rst_n, 0);
    check("rst_wc", word_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", bus.rx_ready, 1);

    // two-instruction image
    wq = '{32'h00000013, 32'h00100093};
    base = wr_count;
    send_frame(32'd2, 0, 1, 8'h00, 0);
    check("t2_csum", last_csum, 8'h92);
    check("t2_mem0", cap_mem[0], 32'h00000013);
    check("t2_mem1", cap_mem[1], 32'h00100093);
    check("t2_writes", wr_count - base, 2);
    check("t2_wc", word_count, 2);
    check("t2_done", load_done, 1);
    check("t2_cpu", cpu_rst_n, 1);

    // bad checksum
    send_frame(32'd2, 0, 0, 8'h00, 2);
    check("t3_err", load_err, 1);
    check("t3_done", load_done, 0);
    check("t3_cpu", cpu_rst_n, 0);

    // oversize length
    base = wr_count;
    send_frame(32'h00001001, 1, 1, 8'h00, 1);
    check("t4_err", load_err, 1);
    check("t4_writes", wr_count - base, 0);

    // garbage prefix with gaps
    cap_mem[0] = 32'hDEADBEEF;
    cap_mem[1] = 32'hDEADBEEF;
    send(8'h00, 2);
    send(8'hFF, 2);
    send(8'h12, 2);
    base = wr_count;
    send_frame(32'd2, 0, 1, 8'h00, 3);
    check("t5_mem0", cap_mem[0], 32'h00000013);
    check("t5_mem1", cap_mem[1], 32'h00100093);
    check("t5_writes", wr_count - base, 2);
    check("t5_done", load_done, 1);

    // resync from DONE, then reset mid-DATA
    send(8'hA5, 0);
    idle(1);
    @(negedge clk);
    check("t6_cpu_drop", cpu_rst_n, 0);
    base = wr_count;
    send(8'h03, 1); send(8'h00, 1);
    send(8'h00, 1); send(8'h00, 1);
    for (int i = 0; i < 6; i++) send(8'(i + 1), 1);
    idle(2);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) send(8'(i + 16), 1);
    idle(2);
    check("t6_writes", wr_count - base, 1);
    check("t6_mem0", cap_mem[0], 32'h04030201);
    check("t6_state", dut.state, S_IDLE);
    check("t6_wc", word_count, 0);

    // empty image
    send_frame(32'd0, 0, 1, 8'h00, 1);
    check("n0_csum", last_csum, 8'h00);
    check("n0_done", load_done, 1);

    // randomized frames
    wq = {};
    for (int f = 0; f < 8; f++) begin
      bit good;
      good = ($urandom_range(3, 0) != 0);
      if ($urandom_range(1, 0) == 1) begin
        send(8'( $urandom_range(8'hA4, 0)), 2);
        send(8'h5A, 2);
      end
      send_frame(32'($urandom_range(20, 1)), 0, good,
                 8'(~last_csum), $urandom_range(3, 0));
      if (!good) begin
        check("rnd_err", load_err, 1);
      end else begin
        check("rnd_done", load_done, 1);
      end
    end

    // full-capacity image
    send_frame(32'(MAXW), 0, 1, 8'h00, 0);
    check("max_wc", word_count, MAXW);
    check("max_last", cap_mem[MAXW-1], last_word);
    check("max_done", load_done, 1);

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
